sipo_frame_ctrl: RTL

//   Sequencer for one unary-MAC serial-in/parallel-out shift register (RIGHT=1 type).
//   - Accepts a serial bit frame of programmable length over a valid/ready handshake.
//   - Drives the register's shift enable and serial input.
//   - Zero-pads the frame to N shifts, then offers the parallel word downstream with valid/ready.

---
 rtl/sipo_frame_ctrl_if.sv | 19 +
 rtl/sipo_frame_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/sipo_frame_ctrl_if.sv
// Bit-stream and word handshakes between a SIPO frame sequencer and its neighbours.
// The master drives bits in and consumes words; the slave is the sequencer.
interface sipo_frame_ctrl_if;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;
    logic word_valid;
    logic word_ready;

    modport master (
        output bit_in, bit_valid, word_ready,
        input  bit_ready, word_valid
    );

    modport slave (
        input  bit_in, bit_valid, word_ready,
        output bit_ready, word_valid
    );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for a right-shifting SIPO register: loads a serial frame, zero-pads it
// to N shifts, then holds the word for downstream. Optional SIPO_CTRL_ONES_COUNT_EN adds ones_count.
module sipo_frame_ctrl #(
    parameter int N     = 16,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] frame_len,
    input  logic             abort,
    sipo_frame_ctrl_if.slave bus,
    output logic             sipo_in,
    output logic             sipo_shift,
    output logic             busy
`ifdef SIPO_CTRL_ONES_COUNT_EN
    ,
    output logic [CNT_W-1:0] ones_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] N_C = CNT_W'(N);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] cnt_inc;
    logic             bit_accept;

    assign cnt_inc    = cnt + CNT_W'(1);
    assign bit_accept = bus.bit_ready & bus.bit_valid;
    assign busy       = (state != IDLE);

    // Outputs decode straight from state; an abort cycle blanks every strobe.
    always_comb begin
        bus.bit_ready  = 1'b0;
        bus.word_valid = 1'b0;
        sipo_in        = 1'b0;
        sipo_shift     = 1'b0;
        if (!abort) begin
            case (state)
                LOAD: begin
                    bus.bit_ready = 1'b1;
                    sipo_in       = bus.bit_in;
                    sipo_shift    = bus.bit_valid;
                end
                PAD:     sipo_shift     = 1'b1;
                HOLD:    bus.word_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
        end else if (abort) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Zero or oversize lengths mean a full-width frame.
                        len   <= (frame_len == '0 || frame_len > N_C) ? N_C : frame_len;
                        cnt   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.bit_valid) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == len) state <= (len == N_C) ? HOLD : PAD;
                    end
                end
                PAD: begin
                    cnt <= cnt_inc;
                    if (cnt_inc == N_C) state <= HOLD;
                end
                HOLD: begin
                    if (bus.word_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SIPO_CTRL_ONES_COUNT_EN
    // Counts only accepted data ones; pad zeros never reach this path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ones_count <= '0;
        end else if (state == IDLE && start && !abort) begin
            ones_count <= '0;
        end else if (bit_accept && bus.bit_in) begin
            ones_count <= ones_count + CNT_W'(1);
        end
    end
`else
    logic unused_accept;
    assign unused_accept = bit_accept;
`endif

endmodule
